spi_block_reader: RTL and testbench
===================================

# spi_block_reader

Hardware sequencer that drives the SPI shifter through a complete SD-card data-block read without per-byte CPU register accesses. It polls for the start token, resets and arms the shifter CRC, reads BLOCK_LEN data bytes and presents them on a valid/ready byte stream, then reads and checks the 16-bit CRC. It sits beside the 68k register path in the SPI controller. While it is active it owns the shifter's start_read, crc_reset and crc_source inputs; the owning mux is outside this block.

## Interface
Parameters:
- BLOCK_LEN, 512, data bytes per block (1..1024).
- TOKEN_TIMEOUT, 1024, maximum 0xFF token polls before giving up (1..65535).

Ports:
- clk  in  1  shifter clock, same clock as the shifter.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a block read; ignored unless idle.
- abort  in  1  one-cycle pulse; cancels any operation.
- active  out  1  high from the cycle after accepted start until done or abort.
- done  out  1  one-cycle pulse at completion.
- status  out  2  result, held until next accepted start: 00 ok, 01 token timeout, 10 CRC error, 11 error token.
- byte_data  out  8  received data byte.
- byte_valid  out  1  byte_data valid.
- byte_ready  in  1  consumer accepts byte.
- sh_start_read  out  1  one-cycle pulse to shifter: shift one byte in (MOSI 0xFF).
- sh_busy  in  1  shifter busy.
- sh_data  in  8  shifter received byte.
- sh_crc_reset  out  1  one-cycle pulse: clear shifter CRC.
- sh_crc_source  out  1  1 = CRC over received bytes.
- sh_crc  in  16  shifter CRC16 (CCITT) result.

## Operation
- States: IDLE, TOK_REQ, TOK_WAIT, CRC_INIT, DAT_REQ, DAT_WAIT, DAT_HOLD, CRC_REQ, CRC_WAIT, CHECK, FINISH.
- IDLE: on start → TOK_REQ, clear poll counter, byte counter, status.
- Any *_REQ state: waits until sh_busy=0, then pulses sh_start_read for one cycle and goes to the matching *_WAIT.
- Any *_WAIT state: waits until sh_busy=0, then samples sh_data in that cycle. The shifter asserts sh_busy in the cycle after sh_start_read, so *_WAIT never samples in the pulse cycle.
- TOK_WAIT, by sampled byte:
  - 0xFF: increment poll counter. If the counter reaches TOKEN_TIMEOUT → status 01, FINISH; else → TOK_REQ.
  - 0xFE: → CRC_INIT.
  - Any other value: → status 11, FINISH.
- CRC_INIT: pulse sh_crc_reset one cycle, with sh_crc_source=1 → DAT_REQ. sh_crc_source is 1 from CRC_INIT through CHECK and 0 elsewhere.
- DAT_WAIT: load byte_data, assert byte_valid → DAT_HOLD.
- DAT_HOLD: on byte_valid && byte_ready, drop byte_valid next cycle and increment byte counter.
  - Counter reaching BLOCK_LEN → CRC_REQ, counter cleared.
  - Otherwise → DAT_REQ.
  - No prefetch: the next shifter read starts only after the consumer accepts.
- CRC_REQ/CRC_WAIT: run twice via the counter (2 CRC bytes); bytes are not output.
- CHECK: the CRC over data plus received CRC must equal 16'h0000. Zero → status 00; else → status 10. → FINISH.
- FINISH: pulse done one cycle → IDLE.
- Counter widths: byte counter $clog2(BLOCK_LEN+1), poll counter 16 bits, no wrap.
- abort in any state: → IDLE next cycle.
  - byte_valid, active and sh_crc_source clear; no done pulse; status unchanged.
  - A byte already in the shifter completes and is discarded.
- start and abort in the same cycle: abort wins.
- start while active: ignored.

## Timing
- Reset values:
  - Outputs: active 0, done 0, status 00, byte_data 8'h00, byte_valid 0, sh_start_read 0, sh_crc_reset 0, sh_crc_source 0.
  - State: IDLE, both counters 0.
- rst mid-operation: immediate return to reset values, no done.
- start → active high next cycle; first sh_start_read 1 cycle after that, if sh_busy=0.
- Shifter byte completion → byte_valid: 1 cycle (WAIT sample cycle, byte_valid registered).
- byte_ready → next sh_start_read: 2 cycles (HOLD→REQ, pulse in REQ).
- byte_ready ignored when byte_valid=0.
- Last CRC byte sampled → CHECK next cycle → done in the cycle after CHECK.
- status updates in the same cycle done rises.
- active falls in the cycle after done.

## Test plan
- Token found: shifter model returns 0xFF ×3, 0xFE, 512 bytes of 0x00..0xFF repeating, then correct CRC bytes → 512 bytes out in order, 4 token polls, done, status 00.
- CRC error: same as above, but the last CRC byte is inverted → 512 bytes out, done, status 10.
- Token timeout: TOKEN_TIMEOUT=8, shifter always returns 0xFF → exactly 8 sh_start_read pulses, done, status 01, no byte_valid.
- Error token: shifter returns 0xFF then 0x05 → done after 2 polls, status 11, sh_crc_reset never pulsed.
- Backpressure: byte_ready held low 20 cycles on byte 10 → byte_data stable, no sh_start_read during the stall; resumes 2 cycles after ready.
- Abort/reset: abort asserted while byte 100 is in DAT_WAIT → IDLE next cycle, no done, byte_valid 0. A following start runs a clean block. rst pulse mid-block → all outputs return to their reset values.

Source files
------------

// File: rtl/spi_block_reader_if.sv
// spi_block_reader_if: control, byte stream and shifter signals of the block reader
interface spi_block_reader_if;
  logic        start;
  logic        abort;
  logic        active;
  logic        done;
  logic [1:0]  status;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        sh_start_read;
  logic        sh_busy;
  logic [7:0]  sh_data;
  logic        sh_crc_reset;
  logic        sh_crc_source;
  logic [15:0] sh_crc;
  modport master (
    output start, abort, byte_ready, sh_busy, sh_data, sh_crc,
    input  active, done, status, byte_data, byte_valid, sh_start_read, sh_crc_reset, sh_crc_source
  );
  modport slave (
    input  start, abort, byte_ready, sh_busy, sh_data, sh_crc,
    output active, done, status, byte_data, byte_valid, sh_start_read, sh_crc_reset, sh_crc_source
  );
endinterface

// File: rtl/spi_block_reader.sv
// spi_block_reader: reads one SD data block through the SPI shifter and streams its bytes out
module spi_block_reader #(
  parameter int BLOCK_LEN     = 512,
  parameter int TOKEN_TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst,
  spi_block_reader_if.slave bus
);
  localparam int CW = $clog2(BLOCK_LEN + 1);
  typedef enum logic [3:0] {
    IDLE, TOK_REQ, TOK_WAIT, CRC_INIT, DAT_REQ, DAT_WAIT, DAT_HOLD, CRC_REQ, CRC_WAIT, CHECK, FINISH
  } state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_poll;
  logic [1:0]    r_status;
  logic [7:0]    r_data;
  logic          r_active, r_done, r_valid, r_rd, r_crc_rst, r_crc_src;
  logic          w_got;
  // sh_busy only rises the cycle after our read pulse, so the pulse cycle is never a completion
  assign w_got             = !bus.sh_busy && !r_rd;
  assign bus.active        = r_active;
  assign bus.done          = r_done;
  assign bus.status        = r_status;
  assign bus.byte_data     = r_data;
  assign bus.byte_valid    = r_valid;
  assign bus.sh_start_read = r_rd;
  assign bus.sh_crc_reset  = r_crc_rst;
  assign bus.sh_crc_source = r_crc_src;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_poll    <= '0;
      r_status  <= 2'b00;
      r_data    <= 8'h00;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_rd      <= 1'b0;
      r_crc_rst <= 1'b0;
      r_crc_src <= 1'b0;
    end else if (bus.abort) begin
      r_state   <= IDLE;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_rd      <= 1'b0;
      r_crc_rst <= 1'b0;
      r_crc_src <= 1'b0;
    end else begin
      r_rd      <= 1'b0;
      r_crc_rst <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_state  <= TOK_REQ;
          r_active <= 1'b1;
          r_poll   <= '0;
          r_cnt    <= '0;
          r_status <= 2'b00;
        end
        TOK_REQ, DAT_REQ, CRC_REQ: if (!bus.sh_busy) begin
          r_rd    <= 1'b1;
          r_state <= r_state == TOK_REQ ? TOK_WAIT : r_state == DAT_REQ ? DAT_WAIT : CRC_WAIT;
        end
        TOK_WAIT: if (w_got) begin
          if (bus.sh_data == 8'hFF) begin
            r_poll <= r_poll + 16'd1;
            if (r_poll == 16'(TOKEN_TIMEOUT - 1)) begin
              r_status <= 2'b01;
              r_done   <= 1'b1;
              r_state  <= FINISH;
            end else r_state <= TOK_REQ;
          end else if (bus.sh_data == 8'hFE) begin
            r_crc_rst <= 1'b1;
            r_crc_src <= 1'b1;
            r_state   <= CRC_INIT;
          end else begin
            r_status <= 2'b11;
            r_done   <= 1'b1;
            r_state  <= FINISH;
          end
        end
        CRC_INIT: r_state <= DAT_REQ;
        DAT_WAIT: if (w_got) begin
          r_data  <= bus.sh_data;
          r_valid <= 1'b1;
          r_state <= DAT_HOLD;
        end
        DAT_HOLD: if (bus.byte_ready) begin
          r_valid <= 1'b0;
          r_cnt   <= r_cnt == CW'(BLOCK_LEN - 1) ? '0 : r_cnt + CW'(1);
          r_state <= r_cnt == CW'(BLOCK_LEN - 1) ? CRC_REQ : DAT_REQ;
        end
        CRC_WAIT: if (w_got) begin
          r_cnt   <= r_cnt == CW'(1) ? '0 : r_cnt + CW'(1);
          r_state <= r_cnt == CW'(1) ? CHECK : CRC_REQ;
        end
        CHECK: begin
          r_status  <= bus.sh_crc == 16'h0000 ? 2'b00 : 2'b10;
          r_done    <= 1'b1;
          r_crc_src <= 1'b0;
          r_state   <= FINISH;
        end
        FINISH: begin
          r_active <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_block_reader.sv
// tb_spi_block_reader: randomized block reads against a shifter model and a stream/CRC reference
module tb_spi_block_reader;
  localparam int BL = 512;
  localparam int TT = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  spi_block_reader_if bus ();
  spi_block_reader #(.BLOCK_LEN(BL), .TOKEN_TIMEOUT(TT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] outs();
    return {bus.active, bus.done, bus.status, bus.byte_data, bus.byte_valid,
            bus.sh_start_read, bus.sh_crc_reset, bus.sh_crc_source};
  endfunction

  // shifter model: busy from the cycle after a read pulse, byte and CRC land together
  logic [7:0]  sq[$];
  logic [7:0]  s_cur;
  logic [15:0] crc;
  int          s_left;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sh_busy <= 1'b0;
      bus.sh_data <= 8'h00;
      crc         <= 16'h0000;
      s_left      <= 0;
    end else begin
      if (bus.sh_crc_reset) crc <= 16'h0000;
      if (bus.sh_start_read) begin
        bus.sh_busy <= 1'b1;
        s_left      <= $urandom_range(1, 3);
        if (sq.size() > 0) s_cur <= sq.pop_front();
        else s_cur <= 8'hFF;
      end else if (bus.sh_busy) begin
        s_left <= s_left - 1;
        if (s_left == 1) begin
          bus.sh_busy <= 1'b0;
          bus.sh_data <= s_cur;
          if (bus.sh_crc_source) crc <= crc_upd(crc, s_cur);
        end
      end
    end
  end
  assign bus.sh_crc = crc;

  int n_rd = 0, n_crst = 0, n_done = 0, n_vld = 0, cyc = 0;
  int t_ready = -1, t_resume = -1, stall_left = 0, stall_bad = 0;
  bit stall_arm = 0, stalling = 0;
  logic [7:0] held;
  logic [7:0] got[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.sh_start_read) begin
      n_rd++;
      if (t_ready >= 0 && t_resume < 0) t_resume = cyc;
    end
    if (bus.sh_crc_reset) n_crst++;
    if (bus.done) n_done++;
    if (bus.byte_valid) begin
      n_vld++;
      if (bus.byte_ready) got.push_back(bus.byte_data);
    end
    if (stalling && (bus.byte_data != held || bus.sh_start_read || !bus.byte_valid)) stall_bad++;
  end

  always @(posedge clk) begin
    #1;
    if (stall_left > 0) begin
      bus.byte_ready = 1'b0;
      stall_left--;
    end else if (stalling) begin
      stalling = 0;
      bus.byte_ready = 1'b1;
      t_ready = cyc;
    end else if (stall_arm && bus.byte_valid && got.size() == 10) begin
      stall_arm = 0;
      stalling = 1;
      held = bus.byte_data;
      bus.byte_ready = 1'b0;
      stall_left = 19;
    end else bus.byte_ready = ($urandom_range(0, 3) != 0);
  end

  // reference: outcome derived from the byte stream the card will send
  logic [7:0] exp_data[$];
  logic [1:0] exp_st;
  int         exp_polls;
  bit         exp_blk;
  task automatic load(input int nff, input logic [7:0] tok, input bit rnd, input bit corrupt);
    logic [15:0] c, r;
    logic [7:0]  b;
    sq.delete();
    got.delete();
    exp_data.delete();
    for (int i = 0; i < nff; i++) sq.push_back(8'hFF);
    sq.push_back(tok);
    c = 16'h0000;
    for (int i = 0; i < BL; i++) begin
      b = rnd ? 8'($urandom) : 8'(i);
      sq.push_back(b);
      exp_data.push_back(b);
      c = crc_upd(c, b);
    end
    if (corrupt) c[7:0] = ~c[7:0];
    sq.push_back(c[15:8]);
    sq.push_back(c[7:0]);
    r = 16'h0000;
    foreach (exp_data[i]) r = crc_upd(r, exp_data[i]);
    r = crc_upd(crc_upd(r, c[15:8]), c[7:0]);
    if (nff >= TT) begin
      exp_st = 2'b01; exp_polls = TT; exp_blk = 0;
    end else if (tok != 8'hFE) begin
      exp_st = 2'b11; exp_polls = nff + 1; exp_blk = 0;
    end else begin
      exp_st = r == 16'h0000 ? 2'b00 : 2'b10; exp_polls = nff + 1; exp_blk = 1;
    end
  endtask

  task automatic kick(input bit timing);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    if (timing) begin
      @(negedge clk);
      chk("start_active", 32'(bus.active), 1);
      chk("start_no_read_yet", 32'(bus.sh_start_read), 0);
      @(negedge clk);
      chk("start_first_read", 32'(bus.sh_start_read), 1);
    end
  endtask

  task automatic run(input string tag, input bit timing);
    int rd0, cr0, dn0, vl0, k, bad;
    rd0 = n_rd; cr0 = n_crst; dn0 = n_done; vl0 = n_vld;
    kick(timing);
    k = 0;
    while (!bus.done && k < 30000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, 32'(bus.done), 1);
    chk({tag, "_status"}, 32'(bus.status), 32'(exp_st));
    @(negedge clk);
    chk({tag, "_end"}, 32'({bus.active, bus.done}), 0);
    chk({tag, "_reads"}, n_rd - rd0, exp_polls + (exp_blk ? BL + 2 : 0));
    chk({tag, "_crcrst"}, n_crst - cr0, 32'(exp_blk));
    chk({tag, "_nbytes"}, got.size(), exp_blk ? BL : 0);
    chk({tag, "_anyvalid"}, 32'(n_vld > vl0), 32'(exp_blk));
    bad = 0;
    if (exp_blk) foreach (exp_data[i]) if (i < got.size() && got[i] != exp_data[i]) bad++;
    chk({tag, "_data"}, bad, 0);
    chk({tag, "_ndone"}, n_done - dn0, 1);
  endtask

  initial begin
    int k, dn0, vl0;
    logic [7:0] tok;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(outs()), 0);
    @(posedge clk); #1 rst = 1'b0;
    load(3, 8'hFE, 0, 0); run("token", 1);
    load(3, 8'hFE, 0, 1); run("crcerr", 0);
    repeat (5) @(negedge clk);
    chk("status_hold", 32'({bus.status, bus.active}), 32'(3'b100));
    load(20, 8'hFF, 0, 0); run("timeout", 0);
    load(1, 8'h05, 0, 0); run("errtok", 0);
    stall_arm = 1;
    load(1, 8'hFE, 1, 0); run("bp", 0);
    chk("bp_stalled", 32'(stall_arm), 0);
    chk("bp_stable", stall_bad, 0);
    chk("bp_resume", t_resume - t_ready, 2);
    load(0, 8'hFE, 1, 0);
    dn0 = n_done;
    kick(0);
    k = 0;
    while (!(got.size() == 100 && bus.sh_busy) && k < 20000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("abort_reach", 32'(k < 20000), 1);
    vl0 = n_vld;
    bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'({bus.active, bus.byte_valid, bus.sh_crc_source}), 0);
    repeat (10) @(negedge clk);
    chk("abort_no_done", n_done - dn0, 0);
    chk("abort_no_valid", n_vld - vl0, 0);
    chk("abort_status", 32'(bus.status), 0);
    load(2, 8'hFE, 1, 0); run("post_abort", 0);
    load(2, 8'hFE, 1, 0);
    dn0 = n_done;
    kick(0);
    k = 0;
    while (got.size() < 50 && k < 20000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rst_reach", 32'({k < 20000, bus.active}), 32'(2'b11));
    #2 rst = 1'b1;
    #1 chk("rst_mid_outputs", 32'(outs()), 0);
    repeat (3) @(negedge clk);
    chk("rst_no_done", n_done - dn0, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      tok = ($urandom_range(0, 3) != 0) ? 8'hFE : 8'($urandom_range(0, 253));
      load($urandom_range(0, 9), tok, 1, 1'($urandom_range(0, 1)));
      run($sformatf("rnd%0d", r), 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
